// File: rtl/mem_bus_arbiter_if.sv
// Bus bundle between two masters, the arbiter and the shared memory slave.
// modport slave is the arbiter's view; modport master is the environment's view.
`timescale 1ns/1ps
interface mem_bus_arbiter_if;
  logic [31:2] m0_adr;
  logic [31:0] m0_dat;
  logic [3:0]  m0_sel;
  logic        m0_we;
  logic        m0_cyc;
  logic [31:0] m0_rdt;
  logic        m0_ack;

  logic [31:2] m1_adr;
  logic [31:0] m1_dat;
  logic [3:0]  m1_sel;
  logic        m1_we;
  logic        m1_cyc;
  logic [31:0] m1_rdt;
  logic        m1_ack;

  logic [31:2] s_adr;
  logic [31:0] s_dat;
  logic [3:0]  s_sel;
  logic        s_we;
  logic        s_cyc;
  logic [31:0] s_rdt;
  logic        s_ack;

  modport slave (
    input  m0_adr, m0_dat, m0_sel, m0_we, m0_cyc,
    input  m1_adr, m1_dat, m1_sel, m1_we, m1_cyc,
    input  s_rdt, s_ack,
    output m0_rdt, m0_ack, m1_rdt, m1_ack,
    output s_adr, s_dat, s_sel, s_we, s_cyc
  );

  modport master (
    output m0_adr, m0_dat, m0_sel, m0_we, m0_cyc,
    output m1_adr, m1_dat, m1_sel, m1_we, m1_cyc,
    output s_rdt, s_ack,
    input  m0_rdt, m0_ack, m1_rdt, m1_ack,
    input  s_adr, s_dat, s_sel, s_we, s_cyc
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter for a single memory slave with combinational bus muxing.
// Optional ack watchdog enabled by defining ARB_WATCHDOG_EN.
`timescale 1ns/1ps
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned M0_PRIORITY    = 1
) (
  input  logic               clk,
  input  logic               reset,
  mem_bus_arbiter_if.slave   bus,
  output logic [1:0]         grant,
  output logic               timeout_err
);

  // State encoding doubles as the grant vector and as the last-granted record.
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    BUSY0 = 2'b01,
    BUSY1 = 2'b10
  } state_t;

  localparam logic [1:0] LAST_NONE = 2'b00;

  state_t     state_q, state_d;
  logic [1:0] last_q, last_d;
  logic       busy;
  logic       sel1;
  logic       req_cyc;
  logic       wd_fire;

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES out of range 1..65535");
  end

  assign busy    = (state_q != IDLE);
  assign sel1    = (state_q == BUSY1);
  assign req_cyc = sel1 ? bus.m1_cyc : bus.m0_cyc;

`ifdef ARB_WATCHDOG_EN
  logic [15:0] wd_cnt_q, wd_cnt_d;

  assign wd_fire = busy && (wd_cnt_q == 16'(TIMEOUT_CYCLES));

  // Held at zero while idle, so every new grant starts counting from zero.
  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (!busy) begin
      wd_cnt_d = '0;
    end else if (!bus.s_ack) begin
      wd_cnt_d = wd_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wd_cnt_q <= '0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
    end
  end
`else
  assign wd_fire = 1'b0;
`endif

  assign timeout_err = wd_fire;
  assign grant       = state_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      last_q  <= LAST_NONE;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_cyc && bus.m1_cyc) begin
          if (last_q == BUSY0) begin
            state_d = BUSY1;
          end else if (last_q == BUSY1) begin
            state_d = BUSY0;
          end else begin
            state_d = (M0_PRIORITY != 0) ? BUSY0 : BUSY1;
          end
        end else if (bus.m0_cyc) begin
          state_d = BUSY0;
        end else if (bus.m1_cyc) begin
          state_d = BUSY1;
        end
      end
      BUSY0, BUSY1: begin
        // Completion, abort and watchdog expiry all end the tenure the same way.
        if (bus.s_ack || !req_cyc || wd_fire) begin
          state_d = IDLE;
          last_d  = state_q;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.s_adr = !busy ? '0 : (sel1 ? bus.m1_adr : bus.m0_adr);
  assign bus.s_dat = !busy ? '0 : (sel1 ? bus.m1_dat : bus.m0_dat);
  assign bus.s_sel = !busy ? '0 : (sel1 ? bus.m1_sel : bus.m0_sel);
  assign bus.s_we  = busy && (sel1 ? bus.m1_we : bus.m0_we);
  assign bus.s_cyc = busy && req_cyc && !wd_fire;

  assign bus.m0_ack = (state_q == BUSY0) && (bus.s_ack || wd_fire);
  assign bus.m1_ack = (state_q == BUSY1) && (bus.s_ack || wd_fire);

  assign bus.m0_rdt = (state_q != BUSY0) ? 32'h0 : (wd_fire ? 32'hDEAD_BEEF : bus.s_rdt);
  assign bus.m1_rdt = (state_q != BUSY1) ? 32'h0 : (wd_fire ? 32'hDEAD_BEEF : bus.s_rdt);

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: single request, round-robin, abort, watchdog, reset.
// A scoreboard queue holds expected acks; a monitor pops and compares on each master ack.
`timescale 1ns/1ps
module tb_mem_bus_arbiter;

  logic       clk;
  logic       reset;
  logic [1:0] grant;
  logic       timeout_err;

  mem_bus_arbiter_if bus ();

  mem_bus_arbiter #(
    .TIMEOUT_CYCLES (4),
    .M0_PRIORITY    (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  int vectors     = 0;
  int miscompares = 0;

  int          exp_id_q[$];
  logic [31:0] exp_rdt_q[$];

  int          slave_lat   = 0;
  logic [31:0] slave_rdata = 32'h0;
  logic        stray_ack   = 1'b0;
  int          wait_cnt    = 0;

  logic [1:0]  rr_exp [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic push_exp(input int id, input logic [31:0] rdt);
    exp_id_q.push_back(id);
    exp_rdt_q.push_back(rdt);
  endtask

  task automatic do_reset();
    reset      = 1'b1;
    bus.m0_adr = '0; bus.m0_dat = '0; bus.m0_sel = '0; bus.m0_we = 1'b0; bus.m0_cyc = 1'b0;
    bus.m1_adr = '0; bus.m1_dat = '0; bus.m1_sel = '0; bus.m1_we = 1'b0; bus.m1_cyc = 1'b0;
    slave_lat  = 0;
    stray_ack  = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Slave model: responds a fixed number of cycles into each tenure.
  initial begin
    bus.s_ack = 1'b0;
    bus.s_rdt = 32'h0;
    forever begin
      @(negedge clk);
      #1;
      if (bus.s_cyc && slave_lat != 0 && wait_cnt == slave_lat - 1) begin
        bus.s_ack = 1'b1;
        bus.s_rdt = slave_rdata;
        wait_cnt  = 0;
      end else begin
        bus.s_ack = stray_ack;
        bus.s_rdt = stray_ack ? 32'h5555_AAAA : 32'h0;
        wait_cnt  = bus.s_cyc ? wait_cnt + 1 : 0;
      end
    end
  end

  // Monitor: every master ack must match the head of the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (bus.m0_ack || bus.m1_ack) begin
        if (exp_id_q.size() == 0) begin
          chk("unexpected_ack", {30'b0, bus.m1_ack, bus.m0_ack}, 32'h0);
        end else begin
          int          id;
          logic [31:0] rdt;
          id  = exp_id_q.pop_front();
          rdt = exp_rdt_q.pop_front();
          chk("sb_ack_master", {30'b0, bus.m1_ack, bus.m0_ack}, (id == 0) ? 32'h1 : 32'h2);
          chk("sb_ack_rdt", (id == 0) ? bus.m0_rdt : bus.m1_rdt, rdt);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rr_exp = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10};

    // Reset state
    do_reset();
    #2;
    chk("rst_grant", {30'b0, grant}, 32'h0);
    chk("rst_timeout", {31'b0, timeout_err}, 32'h0);
    chk("rst_s_cyc", {31'b0, bus.s_cyc}, 32'h0);
    chk("rst_s_adr", {bus.s_adr, 2'b00}, 32'h0);
    chk("rst_acks", {30'b0, bus.m1_ack, bus.m0_ack}, 32'h0);
    chk("rst_m0_rdt", bus.m0_rdt, 32'h0);

    // Single request: m0 reads 0x100, slave answers in the third granted cycle
    @(negedge clk);
    bus.m0_adr = 30'h40; bus.m0_we = 1'b0; bus.m0_sel = 4'hF; bus.m0_cyc = 1'b1;
    slave_lat = 3; slave_rdata = 32'h1234_5678;
    push_exp(0, 32'h1234_5678);
    #2;
    chk("single_c0_grant", {30'b0, grant}, 32'h0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      #2;
      chk($sformatf("single_c%0d_grant", c), {30'b0, grant}, 32'h1);
      chk($sformatf("single_c%0d_m1_ack", c), {31'b0, bus.m1_ack}, 32'h0);
      chk($sformatf("single_c%0d_m0_ack", c), {31'b0, bus.m0_ack}, (c == 3) ? 32'h1 : 32'h0);
    end
    chk("single_s_adr", {bus.s_adr, 2'b00}, 32'h100);
    chk("single_s_sel", {28'b0, bus.s_sel}, 32'hF);
    chk("single_m0_rdt", bus.m0_rdt, 32'h1234_5678);
    @(negedge clk);
    bus.m0_cyc = 1'b0;
    #2;
    chk("single_end_grant", {30'b0, grant}, 32'h0);
    chk("single_end_m0_ack", {31'b0, bus.m0_ack}, 32'h0);

    // Simultaneous requests from reset, round-robin with idle gaps
    do_reset();
    @(negedge clk);
    bus.m0_adr = 30'h100; bus.m0_cyc = 1'b1;
    bus.m1_adr = 30'h200; bus.m1_cyc = 1'b1;
    slave_lat = 1; slave_rdata = 32'h0BAD_F00D;
    push_exp(0, 32'h0BAD_F00D); push_exp(1, 32'h0BAD_F00D);
    push_exp(0, 32'h0BAD_F00D); push_exp(1, 32'h0BAD_F00D);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) @(negedge clk);
      #2;
      chk($sformatf("rr_grant%0d", i), {30'b0, grant}, {30'b0, rr_exp[i]});
      if (rr_exp[i] == 2'b10) chk($sformatf("rr_s_adr%0d", i), {2'b0, bus.s_adr}, 32'h200);
      if (rr_exp[i] == 2'b01) chk($sformatf("rr_s_adr%0d", i), {2'b0, bus.s_adr}, 32'h100);
    end
    @(negedge clk);
    bus.m0_cyc = 1'b0; bus.m1_cyc = 1'b0;
    #2;
    chk("rr_end_grant", {30'b0, grant}, 32'h0);

    // Abort: m1 drops its request with m0 pending
    @(negedge clk);
    bus.m1_cyc = 1'b1; slave_lat = 0;
    #2;
    chk("abort_c0_grant", {30'b0, grant}, 32'h0);
    @(negedge clk);
    bus.m0_cyc = 1'b1;
    #2;
    chk("abort_c1_grant", {30'b0, grant}, 32'h2);
    chk("abort_c1_m0_ack", {31'b0, bus.m0_ack}, 32'h0);
    @(negedge clk);
    #2;
    chk("abort_c2_grant", {30'b0, grant}, 32'h2);
    @(negedge clk);
    bus.m1_cyc = 1'b0;
    #2;
    chk("abort_c3_grant", {30'b0, grant}, 32'h2);
    chk("abort_c3_s_cyc", {31'b0, bus.s_cyc}, 32'h0);
    chk("abort_c3_m1_ack", {31'b0, bus.m1_ack}, 32'h0);
    @(negedge clk);
    #2;
    chk("abort_c4_grant", {30'b0, grant}, 32'h0);
    @(negedge clk);
    slave_lat = 2; slave_rdata = 32'hA0A0_0001;
    push_exp(0, 32'hA0A0_0001);
    #2;
    chk("abort_c5_grant", {30'b0, grant}, 32'h1);
    @(negedge clk);
    #2;
    chk("abort_c6_m0_ack", {31'b0, bus.m0_ack}, 32'h1);
    @(negedge clk);
    bus.m0_cyc = 1'b0;
    #2;
    chk("abort_c7_grant", {30'b0, grant}, 32'h0);

    // Watchdog: m0 write that the slave never acknowledges
    @(negedge clk);
    bus.m0_adr = 30'h0C0; bus.m0_dat = 32'hCAFE_0042; bus.m0_we = 1'b1; bus.m0_cyc = 1'b1;
    slave_lat = 0;
`ifdef ARB_WATCHDOG_EN
    push_exp(0, 32'hDEAD_BEEF);
`endif
    #2;
    chk("wd_c0_grant", {30'b0, grant}, 32'h0);
    @(negedge clk);
    #2;
    chk("wd_s_dat", bus.s_dat, 32'hCAFE_0042);
    chk("wd_s_we", {31'b0, bus.s_we}, 32'h1);
`ifdef ARB_WATCHDOG_EN
    for (int c = 1; c <= 5; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #2;
      end
      chk($sformatf("wd_c%0d_grant", c), {30'b0, grant}, 32'h1);
      chk($sformatf("wd_c%0d_terr", c), {31'b0, timeout_err}, (c == 5) ? 32'h1 : 32'h0);
      chk($sformatf("wd_c%0d_m0_ack", c), {31'b0, bus.m0_ack}, (c == 5) ? 32'h1 : 32'h0);
    end
    chk("wd_fire_rdt", bus.m0_rdt, 32'hDEAD_BEEF);
    chk("wd_fire_s_cyc", {31'b0, bus.s_cyc}, 32'h0);
    @(negedge clk);
    bus.m0_cyc = 1'b0;
    #2;
    chk("wd_end_grant", {30'b0, grant}, 32'h0);
    chk("wd_end_terr", {31'b0, timeout_err}, 32'h0);
`else
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) begin
        @(negedge clk);
        #2;
      end
      chk($sformatf("nowd_c%0d_grant", c), {30'b0, grant}, 32'h1);
      chk($sformatf("nowd_c%0d_terr", c), {31'b0, timeout_err}, 32'h0);
      chk($sformatf("nowd_c%0d_m0_ack", c), {31'b0, bus.m0_ack}, 32'h0);
    end
    @(negedge clk);
    bus.m0_cyc = 1'b0;
    #2;
    chk("nowd_drop_grant", {30'b0, grant}, 32'h1);
    @(negedge clk);
    #2;
    chk("nowd_end_grant", {30'b0, grant}, 32'h0);
`endif
    bus.m0_we = 1'b0;

    // Reset in the middle of an m1 tenure, then a stray slave ack
    @(negedge clk);
    bus.m1_adr = 30'h300; bus.m1_cyc = 1'b1; slave_lat = 0;
    @(negedge clk);
    #2;
    chk("rstmid_grant_before", {30'b0, grant}, 32'h2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rstmid_grant", {30'b0, grant}, 32'h0);
    chk("rstmid_s_cyc", {31'b0, bus.s_cyc}, 32'h0);
    chk("rstmid_m1_ack", {31'b0, bus.m1_ack}, 32'h0);
    bus.m1_cyc = 1'b0;
    stray_ack  = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      if (c > 0) @(negedge clk);
      #2;
      chk($sformatf("stray%0d_acks", c), {30'b0, bus.m1_ack, bus.m0_ack}, 32'h0);
      chk($sformatf("stray%0d_grant", c), {30'b0, grant}, 32'h0);
    end
    stray_ack = 1'b0;

    @(negedge clk);
    #4;
    chk("sb_empty", exp_id_q.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 255, which is the maximum number of cycles a granted transfer may wait for slave ack (range 1..65535).
REQ-002 The block SHALL have parameter M0_PRIORITY, default 1: 1 = master 0 (CPU) wins simultaneous requests after reset; 0 = master 1 wins.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 The block SHALL have, for master index m in {0,1}, ports m<m>_adr input [31:2], m<m>_dat input [31:0], m<m>_sel input [3:0], m<m>_we input 1, m<m>_cyc input 1 (request), m<m>_rdt output [31:0], m<m>_ack output 1.
REQ-006 The block SHALL have ports s_adr output [31:2], s_dat output [31:0], s_sel output [3:0], s_we output 1, s_cyc output 1, s_rdt input [31:0], s_ack input 1: the shared memory slave.
REQ-007 The block SHALL have port grant, output [1:0]: 2'b01 = m0 owns bus, 2'b10 = m1 owns bus, 2'b00 = idle; never 2'b11.
REQ-008 The block SHALL have port timeout_err, output 1 bit: a one-cycle pulse when a transfer is terminated by the watchdog.

Function
REQ-009 The FSM SHALL have states IDLE, BUSY0, BUSY1, held in registers.
REQ-010 In IDLE with exactly one mX_cyc high at edge n, the state SHALL be BUSYX from edge n (grant visible cycle n+1).
REQ-011 In IDLE with both requests high, the block SHALL grant the master not granted last (round-robin); before any grant since reset, M0_PRIORITY decides.
REQ-012 In BUSYX, s_adr/s_dat/s_sel/s_we SHALL combinationally equal master X's signals and s_cyc SHALL equal mX_cyc; in IDLE all s_* outputs SHALL be 0.
REQ-013 mX_ack SHALL equal s_ack only in BUSYX and be 0 otherwise; mX_rdt SHALL equal s_rdt in BUSYX and be 32'h0 otherwise.
REQ-014 On s_ack in BUSYX, the FSM SHALL return to IDLE at that edge, record X as last granted, and the next grant SHALL be no earlier than one cycle later (one idle cycle between transfers).
REQ-015 If mX_cyc drops in BUSYX without s_ack, the FSM SHALL return to IDLE (abort); last-granted SHALL still update to X.
REQ-016 A non-granted master's request SHALL be held pending with no ack until granted; no request SHALL be lost or starved beyond one intervening transfer.
REQ-017 s_ack while IDLE SHALL be ignored and not reach either master.

Reset
REQ-018 On reset the FSM SHALL be IDLE, grant 2'b00, timeout_err 0, watchdog counter 0, last-granted "none"; all s_* and m*_ack/m*_rdt outputs 0.
REQ-019 Reset asserted mid-transfer SHALL force IDLE immediately (asynchronously); no ack SHALL be delivered for the aborted transfer.

Configuration
REQ-020 With macro ARB_WATCHDOG_EN defined, a 16-bit counter SHALL clear on entry to BUSYX, increment each BUSYX cycle without s_ack, and when it reaches TIMEOUT_CYCLES the block SHALL drive mX_ack=1 with mX_rdt=32'hDEAD_BEEF for one cycle, pulse timeout_err, drop s_cyc that cycle, and return to IDLE.
REQ-021 Without ARB_WATCHDOG_EN the counter SHALL not exist, timeout_err SHALL be tied 0, and a transfer SHALL wait for s_ack indefinitely.

Verification
REQ-022 Single request: m0 reads 0x100, slave acks after 3 cycles with 0x12345678 -> grant=01 from cycle 1, m0_ack one cycle, m0_rdt=0x12345678, m1_ack never.
REQ-023 Simultaneous: both request continuously from reset, slave acks each after 1 cycle, M0_PRIORITY=1 -> grant sequence 01,00,10,00,01,00,10, one idle cycle between each.
REQ-024 Abort: m1 granted, drops m1_cyc after 2 cycles with no s_ack -> IDLE next cycle, m1_ack stays 0, pending m0 granted next.
REQ-025 Watchdog (ARB_WATCHDOG_EN, TIMEOUT_CYCLES=4): m0 write, slave never acks -> m0_ack and timeout_err pulse 4 cycles after grant, m0_rdt=0xDEADBEEF, then IDLE; without macro, grant stays 01.
REQ-026 Reset mid-transfer: assert reset while grant=10 -> grant=00, s_cyc=0 in same cycle without clock edge; stray s_ack afterwards delivers no master ack.
